// File: rtl/dvsd_8216m1_mac.sv
// Frame accumulator: sums LEN (1..16) unsigned 16-bit products per frame and
// presents the modulo-2^ACC_W total on a valid/ready output with a sticky carry flag.
module dvsd_8216m1_mac #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      m,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_W-1:0] len,
    input  logic             clr,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic [7:0]       frame_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W:0]     cnt_q, cnt_d;
    logic [LEN_W:0]     len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    logic [LEN_W:0]     len_eff;
    logic [LEN_W:0]     cnt_inc;
    logic [ACC_W:0]     sum_ext;
    logic               xfer;

    always_comb begin
        // A zero length field encodes the maximum frame of 2^LEN_W products.
        len_eff = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
        cnt_inc = cnt_q + (LEN_W+1)'(1);
        sum_ext = {1'b0, acc_q} + (ACC_W+1)'(m);
        xfer    = in_valid && (state_q != HOLD);

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    len_d = len_eff;
                    acc_d = ACC_W'(m);
                    cnt_d = (LEN_W+1)'(1);
                    ovf_d = 1'b0;
                    if (len_eff == (LEN_W+1)'(1)) begin
                        state_d     = HOLD;
                        out_sum_d   = ACC_W'(m);
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_d = sum_ext[ACC_W-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d     = HOLD;
                        out_sum_d   = sum_ext[ACC_W-1:0];
                        out_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over any transfer or handshake decided above; frame_cnt survives.
        if (clr) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_sum_d   = '0;
            out_valid_d = 1'b0;
            frame_cnt_d = frame_cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and every flop,
    // including the datapath registers, gets an explicit async reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign busy      = (state_q != IDLE);
    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dvsd_8216m1_mac.sv
// Scoreboard bench: a 24-bit and a 17-bit accumulator share the same stimulus;
// per-frame expected sums are queued and popped by a monitor at each output handshake.
module tb_dvsd_8216m1_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] m = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  len = '0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, ovf, busy;
    logic [23:0] out_sum;
    logic [7:0]  frame_cnt;

    logic        in_ready17, out_valid17, ovf17, busy17;
    logic [16:0] out_sum17;
    logic [7:0]  frame_cnt17;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [23:0] sum24;
        logic        ovf24;
        logic [16:0] sum17;
        logic        ovf17;
        logic [7:0]  fcnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dvsd_8216m1_mac #(.ACC_W(24), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .m(m), .in_valid(in_valid), .in_ready(in_ready),
        .len(len), .clr(clr), .out_sum(out_sum), .out_valid(out_valid),
        .out_ready(out_ready), .ovf(ovf), .frame_cnt(frame_cnt), .busy(busy)
    );

    dvsd_8216m1_mac #(.ACC_W(17), .LEN_W(4)) dut17 (
        .clk(clk), .rst_n(rst_n), .m(m), .in_valid(in_valid), .in_ready(in_ready17),
        .len(len), .clr(clr), .out_sum(out_sum17), .out_valid(out_valid17),
        .out_ready(out_ready), .ovf(ovf17), .frame_cnt(frame_cnt17), .busy(busy17)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic expect_frame(input string tag, input logic [23:0] s24, input logic o24,
                                input logic [16:0] s17, input logic o17, input logic [7:0] fc);
        exp_t e;
        e.sum24 = s24; e.ovf24 = o24; e.sum17 = s17; e.ovf17 = o17; e.fcnt = fc; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Present one product and let one edge pass; in_valid stays high for back-to-back use.
    task automatic send(input logic [15:0] val, input logic [3:0] l);
        m = val;
        len = l;
        in_valid = 1'b1;
        check("in_ready_before_xfer", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) begin
            fail_now("drain_timeout");
        end else begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    // Monitor: one pop per output handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_sum24"}, 32'(out_sum), 32'(e.sum24));
                check({e.tag, "_ovf24"}, 32'(ovf), 32'(e.ovf24));
                check({e.tag, "_valid17"}, 32'(out_valid17), 32'd1);
                check({e.tag, "_sum17"}, 32'(out_sum17), 32'(e.sum17));
                check({e.tag, "_ovf17"}, 32'(ovf17), 32'(e.ovf17));
                check({e.tag, "_fcnt"}, 32'(frame_cnt), 32'(e.fcnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // F1: single-product frame.
        expect_frame("f1", 24'h00FE01, 1'b0, 17'h0FE01, 1'b0, 8'd0);
        send(16'hFE01, 4'd1);
        in_valid = 1'b0;
        check("f1_latency_valid", 32'(out_valid), 32'd1);
        check("f1_busy_hold", 32'(busy), 32'd1);
        drain();
        check("f1_fcnt_after", 32'(frame_cnt), 32'd1);

        // F2: len=3 with two-cycle gaps; out_valid must rise right after the third transfer.
        expect_frame("f2", 24'h000115, 1'b0, 17'h00115, 1'b0, 8'd1);
        send(16'h0006, 4'd3);
        idle(2);
        send(16'h000F, 4'd3);
        idle(2);
        check("f2_not_yet_valid", 32'(out_valid), 32'd0);
        send(16'h0100, 4'd3);
        in_valid = 1'b0;
        check("f2_latency_valid", 32'(out_valid), 32'd1);
        drain();

        // F3: len=0 means 16 back-to-back products.
        expect_frame("f3", 24'h0FE010, 1'b0, 17'h1E010, 1'b1, 8'd2);
        for (int i = 0; i < 16; i++) begin
            send(16'hFE01, 4'd0);
            if (i == 14) check("f3_valid_before_last", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        drain();

        // F4: held output with in_valid asserted; 17-bit instance overflows.
        expect_frame("f4", 24'h02FA03, 1'b0, 17'h0FA03, 1'b1, 8'd3);
        send(16'hFE01, 4'd3);
        send(16'hFE01, 4'd3);
        send(16'hFE01, 4'd3);
        m = 16'h1234;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("f4_hold_in_ready", 32'(in_ready), 32'd0);
            check("f4_hold_sum", 32'(out_sum), 32'h02FA03);
            check("f4_hold_sum17", 32'(out_sum17), 32'h0FA03);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        check("f4_idle_after", 32'(busy), 32'd0);

        // F5: starts the cycle after the handshake; len changes mid-frame are ignored.
        expect_frame("f5", 24'h000006, 1'b0, 17'h00006, 1'b0, 8'd4);
        send(16'h0001, 4'd3);
        check("f5_ovf17_cleared", 32'(ovf17), 32'd0);
        send(16'h0002, 4'd1);
        check("f5_len_ignored", 32'(out_valid), 32'd0);
        send(16'h0003, 4'd1);
        in_valid = 1'b0;
        drain();
        check("f5_fcnt_after", 32'(frame_cnt), 32'd5);

        // Clear mid-frame with a product presented: discarded, frame_cnt kept.
        send(16'h0011, 4'd4);
        send(16'h0022, 4'd4);
        m = 16'h0033;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_out_sum", 32'(out_sum), 32'd0);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_fcnt", 32'(frame_cnt), 32'd5);

        expect_frame("f6", 24'h000030, 1'b0, 17'h00030, 1'b0, 8'd5);
        send(16'h0010, 4'd2);
        send(16'h0020, 4'd2);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset mid-frame.
        send(16'h0055, 4'd4);
        send(16'h0066, 4'd4);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_sum", 32'(out_sum), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_fcnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        expect_frame("f7", 24'h000ABC, 1'b0, 17'h00ABC, 1'b0, 8'd0);
        send(16'h0ABC, 4'd1);
        in_valid = 1'b0;
        drain();
        check("f7_fcnt_after", 32'(frame_cnt), 32'd1);

        idle(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dvsd_8216m1_mac.md
DVSD_8216M1_MAC -- requirements
Module: dvsd_8216m1_mac

Interface
REQ-001 Parameter ACC_W, default 24: accumulator/result width, legal range 16..32.
REQ-002 Parameter LEN_W, fixed 4: frame-length field width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 m  in  16  unsigned product; m[k] is driven from multiplier output mk (m0..m15).
REQ-007 in_valid  in  1  m holds a product to accumulate.
REQ-008 in_ready  out  1  block accepts m this cycle.
REQ-009 len  in  LEN_W  products per frame, sampled with the first product of a frame; 0 means 16.
REQ-010 clr  in  1  synchronous abort/clear.
REQ-011 out_sum  out  ACC_W  frame sum, modulo 2^ACC_W.
REQ-012 out_valid  out  1  out_sum holds a completed frame.
REQ-013 out_ready  in  1  consumer takes out_sum.
REQ-014 ovf  out  1  a carry out of bit ACC_W-1 occurred during the current/held frame.
REQ-015 frame_cnt  out  8  completed-frame count, wraps 255->0.
REQ-016 busy  out  1  high in ACC and HOLD.

Function
REQ-017 Transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; the output handshake SHALL complete on a rising edge with out_valid=1 and out_ready=1.
REQ-018 The FSM SHALL have exactly three states: IDLE, ACC, HOLD; in_ready=1 in IDLE and ACC, 0 in HOLD.
REQ-019 IDLE, on transfer: latch len (0->16), acc<=m, cnt<=1, ovf<=0; go to HOLD if effective len=1, else go to ACC.
REQ-020 ACC, on transfer: acc<=acc+m (truncated to ACC_W), ovf<=ovf OR carry, cnt<=cnt+1; when the accepted product is the len-th, go to HOLD.
REQ-021 ACC with in_valid=0: hold all state; gaps of any length are allowed.
REQ-022 Entry into HOLD: out_valid=1 and out_sum=final acc, both registered, on the cycle after the last product transfer (latency 1).
REQ-023 HOLD: out_sum, ovf, and out_valid SHALL remain stable until the handshake; in_valid is ignored.
REQ-024 HOLD, on the handshake: out_valid<=0, frame_cnt<=frame_cnt+1, go to IDLE; the next product may be accepted no earlier than the following cycle.
REQ-025 clr=1 SHALL take priority over every transfer and handshake: at the edge, go to IDLE with acc, cnt, ovf, out_sum=0 and out_valid=0; frame_cnt SHALL be retained; the product presented that cycle SHALL be discarded.
REQ-026 len SHALL be ignored except at the first transfer of a frame.
REQ-027 busy SHALL equal (state != IDLE); all outputs SHALL be registers or decodes of state only, with no combinational path from in_valid or m.

Reset
REQ-028 When rst_n=0, the block SHALL immediately and asynchronously set state=IDLE and acc, cnt, out_sum, out_valid, ovf, and frame_cnt to 0; in_ready SHALL be 1 and busy SHALL be 0.
REQ-029 Reset SHALL abort any frame in progress or held with no output handshake and no increment of frame_cnt.
REQ-030 The first transfer SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-031 len=1, m=0xFE01 -> next cycle: out_valid=1, out_sum=0x00FE01, ovf=0; after the handshake, frame_cnt=1.
REQ-032 len=3, products 0x0006, 0x000F, 0x0100 with 2-cycle in_valid gaps -> out_sum=0x000115, with out_valid rising exactly 1 cycle after the third transfer.
REQ-033 len=0, 16 back-to-back products of 0xFE01 -> out_sum=0x0FE010, ovf=0; in_ready stays high through all 16 transfers.
REQ-034 HOLD with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0, out_sum stable, no product absorbed; with out_ready=1, the state returns to IDLE and the next product starts a new frame.
REQ-035 ACC_W=17, len=3, 3x 0xFE01 -> out_sum=0x0FA03, ovf=1; ovf clears at the first transfer of the next frame.
REQ-036 rst_n pulsed low mid-ACC -> all outputs read 0 during reset, with in_ready=1; separately, clr=1 mid-ACC with in_valid=1 -> the next cycle is IDLE, out_sum=0, and frame_cnt is unchanged.
